mem_copy_master: RTL
====================

Name: mem_copy_master

Overview:
- Bus initiator that drives the 16-bit data memory port (13-bit address, WriteData, MemRead, MemWrite, ReadData). It copies a block of LEN words from SRC to DST, one word at a time: a read cycle, then a write cycle.
- Also accumulates a running 16-bit checksum of the copied words.
- Sits beside the datapath and owns the memory port while busy. An external mux selects between this block and the CPU.

Parameters:
- AW, 13, memory address width.
- DW, 16, memory data width.
- LW, 13, width of the length field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  input  AW  first source word address; latched on an accepted start.
- dst_addr  input  AW  first destination word address; latched on an accepted start.
- len  input  LW  number of words to copy; latched on an accepted start.
- address  output  AW  memory address.
- WriteData  output  DW  memory write data.
- MemRead  output  1  memory read strobe; ReadData is combinational and valid in the same cycle.
- MemWrite  output  1  memory write strobe; memory commits on the next rising edge.
- ReadData  input  DW  memory read data.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse when the copy completes.
- checksum  output  DW  modulo-2^16 sum of all words copied in the current or last job.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, regardless of state:
  - FSM to IDLE.
  - address, WriteData, MemRead, MemWrite, busy, done and checksum all 0.
  - Internal counters cleared.
- Reset mid-copy aborts immediately. Words already written stay in memory; no further accesses are made.
- States:
  - IDLE: all strobes 0. When start=1:
    - latch src, dst, len; clear index i and checksum.
    - go to DONE if len==0, else go to RD.
  - RD: MemRead=1, MemWrite=0, address=src+i.
    - At the clock edge: capture ReadData into data_q and add it to checksum.
    - Go to WR.
  - WR: MemWrite=1, MemRead=0, address=dst+i, WriteData=data_q.
    - At the clock edge: i<=i+1.
    - Go to DONE if i+1==len, else go to RD.
  - DONE: done=1 for exactly this one cycle, strobes 0. Go to IDLE.
- MemRead and MemWrite are never high in the same cycle.
- Outside RD and WR, address holds 0 and WriteData holds its last value.
- Timing:
  - Two cycles per word.
  - Total cycles from the start edge to the done pulse: 2*len+1 (len>0), or 1 (len==0).
- busy=1 in RD, WR and DONE; 0 in IDLE.
- start asserted while busy is ignored; no queuing.
- Address arithmetic is modulo 2^AW: src+i and dst+i wrap from 8191 to 0.
- len wraps the same way: a value of 0 means zero words, not 2^LW.
- Overlapping regions are copied in ascending order, word by word, with no hazard protection:
  - dst > src with overlap propagates source words forward (defined, documented behaviour).
  - dst == src rewrites each word with itself.
- checksum holds its value after DONE until the next accepted start or reset.

Test Plan:
- Basic copy: preload mem[100..103]=10,2,3,4; start with src=100, dst=150, len=4 -> mem[150..153]=10,2,3,4; done pulses exactly 9 cycles after the start edge; checksum=0x0013.
- Zero length: start with len=0 -> done on the next cycle, no MemRead or MemWrite ever asserted, checksum=0.
- Start while busy: during a len=3 copy, pulse start with src=0, dst=0, len=5 -> ignored; only 3 words copied; one done pulse.
- Address wrap: src=8190, dst=20, len=3, with mem[8190]=A, mem[8191]=B, mem[0]=C -> mem[20..22]=A,B,C. Use a full-size memory model in the bench.
- Overlap forward: mem[10..12]=1,2,3; src=10, dst=11, len=2 -> mem[11]=1, mem[12]=1.
- Reset mid-op: len=4 copy; drop rst_n asynchronously while in the second WR -> all outputs 0 in the same cycle; exactly one destination word written; after release, a new start runs normally.
- Checker across all runs: assert that MemRead and MemWrite are never high together.

Source files
------------

// File: rtl/mem_copy_master.sv
// Block-copy bus initiator: moves LEN words from SRC to DST through the data memory
// port, one read cycle then one write cycle per word, and keeps a running checksum.
module mem_copy_master #(
  parameter int AW = 13,
  parameter int DW = 16,
  parameter int LW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] address,
  output logic [DW-1:0] WriteData,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] ReadData,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q, i_q, i_inc;
  logic [DW-1:0] data_q, sum_q;

  assign i_inc = i_q + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      i_q    <= '0;
      data_q <= '0;
      sum_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          len_q <= len;
          i_q   <= '0;
          sum_q <= '0;
        end
        RD: begin
          data_q <= ReadData;
          sum_q  <= sum_q + ReadData;
        end
        WR:      i_q <= i_inc;
        default: ;
      endcase
    end
  end

  // Strobes and address decode purely from state, so an asynchronous reset
  // clears them in the same cycle without waiting for a clock edge.
  always_comb begin
    state_nxt = state;
    address   = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : RD;
      RD: begin
        MemRead   = 1'b1;
        address   = src_q + AW'(i_q);
        state_nxt = WR;
      end
      WR: begin
        MemWrite  = 1'b1;
        address   = dst_q + AW'(i_q);
        state_nxt = (i_inc == len_q) ? DONE : RD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // data_q only changes at the end of RD, so WriteData keeps the last written word elsewhere.
  assign WriteData = data_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign checksum  = sum_q;

endmodule
